// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// States, parameter defaults and the word-index width helper live here.
package dmem_pkg;

  localparam int DEPTH_DEFAULT   = 64;
  localparam int LATENCY_DEFAULT = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bits needed to index DEPTH words; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-masked word RAM: synchronous write, asynchronous (combinational) read.
// Holds no reset; contents persist across responder resets.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array is deliberately not reset; clearing it would
  // turn the RAM into a huge flop bank and break RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: IDLE/WAIT/RESP handshake with Stall/Ready.
// Optional committed-write counter enabled by defining DMEM_WRCOUNT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteMask,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Stall,
  output logic        Err,
  output logic [15:0] WrCount
);

  localparam int AW = idx_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        wr_q;
  logic        rd_q;

  logic        req;
  logic        accept;
  logic [29:0] word_idx;
  logic        err;
  logic        commit;
  logic [31:0] rdata;

  assign req      = MemWrite | MemRead;
  assign accept   = (state == IDLE) && req;
  assign word_idx = adr_q[31:2];
  assign err      = (adr_q[1:0] != 2'b00) || (word_idx >= 30'(DEPTH));
  // A reset landing on the RESP edge still discards the pending write.
  assign commit   = (state == RESP) && wr_q && !err && !reset;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture; inputs are only sampled at acceptance so later changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      adr_q   <= DataAdr;
      wdata_q <= WriteData;
      mask_q  <= ByteMask;
      wr_q    <= MemWrite;
      rd_q    <= MemRead & ~MemWrite;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    Stall     = 1'b0;
    Ready     = 1'b0;
    Err       = 1'b0;
    ReadData  = '0;
    case (state)
      IDLE: begin
        if (req) begin
          Stall = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        Stall = 1'b1;
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP: begin
        Ready     = 1'b1;
        Err       = err;
        if (rd_q && !err) ReadData = rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (commit),
    .waddr (word_idx[AW-1:0]),
    .wdata (wdata_q),
    .wmask (mask_q),
    .raddr (word_idx[AW-1:0]),
    .rdata (rdata)
  );

`ifdef DMEM_WRCOUNT_EN
  logic [15:0] wr_count;

  always_ff @(posedge clk) begin
    if (reset)       wr_count <= '0;
    else if (commit) wr_count <= wr_count + 16'd1;
  end

  assign WrCount = wr_count;
`else
  assign WrCount = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench for dmem_responder (DEPTH=64, LATENCY=2) plus
// hand-written reset, simultaneous-request and write-count sequences.
module tb_dmem_responder;

  localparam int LAT = 2;
`ifdef DMEM_WRCOUNT_EN
  localparam int EXP_WC = 3;
`else
  localparam int EXP_WC = 0;
`endif

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [3:0]  ByteMask;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Stall;
  logic        Err;
  logic [15:0] WrCount;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ByteMask  (ByteMask),
    .ReadData  (ReadData),
    .Ready     (Ready),
    .Stall     (Stall),
    .Err       (Err),
    .WrCount   (WrCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [3:0]  mask;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, hold it while stalled, return response and timing.
  task automatic do_op(input logic we, input logic re, input logic [31:0] adr,
                       input logic [31:0] wd, input logic [3:0] m,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int stalls, output logic stall_at_ready);
    @(negedge clk);
    MemWrite  = we;
    MemRead   = re;
    DataAdr   = adr;
    WriteData = wd;
    ByteMask  = m;
    #1;
    lat            = 0;
    stalls         = Stall ? 1 : 0;
    rd             = '0;
    er             = 1'b0;
    stall_at_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (Ready) begin
        lat            = i;
        rd             = ReadData;
        er             = Err;
        stall_at_ready = Stall;
        break;
      end
      if (Stall) stalls++;
    end
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    ByteMask  = '0;
    @(posedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          stalls;
  logic        sar;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'd100, 32'd7,          4'hF, 32'd0,          1'b0, "wr7_100"};
    vecs[1]  = '{1'b0, 1'b1, 32'd100, 32'd0,          4'h0, 32'd7,          1'b0, "rd100_7"};
    vecs[2]  = '{1'b1, 1'b0, 32'd96,  32'hAABBCCDD,   4'hF, 32'd0,          1'b0, "wr_96_full"};
    vecs[3]  = '{1'b1, 1'b0, 32'd96,  32'h11223344,   4'h5, 32'd0,          1'b0, "wr_96_mask5"};
    vecs[4]  = '{1'b0, 1'b1, 32'd96,  32'd0,          4'h0, 32'hAA22CC44,   1'b0, "rd96_merged"};
    vecs[5]  = '{1'b0, 1'b1, 32'd101, 32'd0,          4'h0, 32'd0,          1'b1, "rd101_misalign"};
    vecs[6]  = '{1'b1, 1'b0, 32'd256, 32'hDEADBEEF,   4'hF, 32'd0,          1'b1, "wr256_range"};
    vecs[7]  = '{1'b0, 1'b1, 32'd100, 32'd0,          4'h0, 32'd7,          1'b0, "rd100_after_err"};
    vecs[8]  = '{1'b0, 1'b1, 32'd96,  32'd0,          4'h0, 32'hAA22CC44,   1'b0, "rd96_after_err"};
    vecs[9]  = '{1'b1, 1'b1, 32'd100, 32'd9,          4'hF, 32'd0,          1'b0, "wr_rd_both"};
    vecs[10] = '{1'b0, 1'b1, 32'd100, 32'd0,          4'h0, 32'd9,          1'b0, "rd100_9"};
    vecs[11] = '{1'b1, 1'b0, 32'd100, 32'hFFFFFFFF,   4'h0, 32'd0,          1'b0, "wr100_mask0"};
    vecs[12] = '{1'b0, 1'b1, 32'd100, 32'd0,          4'h0, 32'd9,          1'b0, "rd100_still9"};
    vecs[13] = '{1'b1, 1'b0, 32'd252, 32'h12345678,   4'hF, 32'd0,          1'b0, "wr252_last"};
    vecs[14] = '{1'b0, 1'b1, 32'd252, 32'd0,          4'h0, 32'h12345678,   1'b0, "rd252_last"};
    vecs[15] = '{1'b0, 1'b1, 32'd256, 32'd0,          4'h0, 32'd0,          1'b1, "rd256_range"};

    reset     = 1'b1;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    ByteMask  = '0;

    // Reset state, and Stall still follows the request while reset holds IDLE.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",    32'(Ready),    32'd0);
    check("rst_err",      32'(Err),      32'd0);
    check("rst_readdata", ReadData,      32'd0);
    check("rst_stall",    32'(Stall),    32'd0);
    check("rst_wrcount",  32'(WrCount),  32'd0);
    @(negedge clk);
    MemWrite = 1'b1;
    #1;
    check("rst_stall_req", 32'(Stall), 32'd1);
    @(posedge clk);
    #1;
    check("rst_hold_idle_ready", 32'(Ready), 32'd0);
    check("rst_hold_idle_stall", 32'(Stall), 32'd1);
    @(negedge clk);
    MemWrite = 1'b0;
    reset    = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].we, vecs[i].re, vecs[i].adr, vecs[i].wd, vecs[i].mask, rd, er, lat, stalls, sar);
      check({vecs[i].name, "_rdata"},  rd,          vecs[i].exp_rd);
      check({vecs[i].name, "_err"},    32'(er),     32'(vecs[i].exp_err));
      check({vecs[i].name, "_lat"},    32'(lat),    32'(LAT));
      check({vecs[i].name, "_stalls"}, 32'(stalls), 32'(LAT));
      check({vecs[i].name, "_stall_in_resp"}, 32'(sar), 32'd0);
    end

    // Back-to-back: request held through RESP is re-accepted in the next IDLE cycle.
    @(negedge clk);
    MemRead = 1'b1;
    DataAdr = 32'd100;
    repeat (LAT) @(posedge clk);
    #1;
    check("b2b_first_ready", 32'(Ready), 32'd1);
    check("b2b_first_data",  ReadData,   32'd9);
    @(posedge clk);
    #1;
    check("b2b_idle_stall", 32'(Stall), 32'd1);
    check("b2b_idle_ready", 32'(Ready), 32'd0);
    repeat (LAT) @(posedge clk);
    #1;
    check("b2b_second_ready", 32'(Ready), 32'd1);
    MemRead = 1'b0;
    DataAdr = '0;
    @(posedge clk);

    // Reset during WAIT of a write of 5 to 100: request dropped, no commit.
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAdr   = 32'd100;
    WriteData = 32'd5;
    ByteMask  = 4'hF;
    @(posedge clk);
    #1;
    check("rstw_wait_stall", 32'(Stall), 32'd1);
    check("rstw_wait_ready", 32'(Ready), 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
    check("rstw_ready",    32'(Ready),   32'd0);
    check("rstw_stall",    32'(Stall),   32'd0);
    check("rstw_readdata", ReadData,     32'd0);
    check("rstw_wrcount",  32'(WrCount), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rstw_no_late_ready", 32'(Ready), 32'd0);
    do_op(1'b0, 1'b1, 32'd100, 32'd0, 4'h0, rd, er, lat, stalls, sar);
    check("rstw_word_kept", rd, 32'd9);
    check("rstw_word_err",  32'(er), 32'd0);

    // Three good writes plus one misaligned write.
    do_op(1'b1, 1'b0, 32'd0, 32'h01, 4'hF, rd, er, lat, stalls, sar);
    do_op(1'b1, 1'b0, 32'd4, 32'h02, 4'hF, rd, er, lat, stalls, sar);
    do_op(1'b1, 1'b0, 32'd1, 32'h03, 4'hF, rd, er, lat, stalls, sar);
    check("wc_err_write_err", 32'(er), 32'd1);
    do_op(1'b1, 1'b0, 32'd8, 32'h04, 4'hF, rd, er, lat, stalls, sar);
    check("wc_count", 32'(WrCount), 32'(EXP_WC));
    do_op(1'b0, 1'b1, 32'd0, 32'd0, 4'h0, rd, er, lat, stalls, sar);
    check("wc_rd0", rd, 32'h01);
    do_op(1'b0, 1'b1, 32'd8, 32'd0, 4'h0, rd, er, lat, stalls, sar);
    check("wc_rd8", rd, 32'h04);
    check("wc_count_after_reads", 32'(WrCount), 32'(EXP_WC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
